regfile_read_stage: RTL
=======================

// Module: regfile_read_stage
// PURPOSE
//  Consumer end of the writeback interface. Holds the 32x32 integer register file and accepts
//  writes from writeback (RegWrite/RegDest/data_wb). Serves two registered source-operand reads
//  to execute. A per-register pending-write scoreboard raises hazard_stall when a source
//  register still has an older write in flight.
// PARAMETERS
//  XLEN          32  data width
//  MAX_INFLIGHT  3   max outstanding writes per register; pending counter saturation point
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, asynchronous, active-high
//  stall          in   1     global pipeline stall (same net writeback sees)
//  flush          in   1     branch taken (writeback out_PCSrc); squash younger work
//  wb_RegWrite    in   1     writeback write enable
//  wb_RegDest     in   5     writeback destination register
//  wb_data        in   XLEN  writeback data (data_wb)
//  in_valid       in   1     decode presents a valid instruction
//  in_rs1         in   5     source 1 address
//  in_rs2         in   5     source 2 address
//  in_RegWrite    in   1     instruction will write rd
//  in_RegDest     in   5     instruction rd
//  hazard_stall   out  1     combinational; decode must hold instruction
//  out_valid      out  1     registered operands valid
//  out_rs1_data   out  XLEN  registered source 1 value
//  out_rs2_data   out  XLEN  registered source 2 value
//  out_RegWrite   out  1     registered copy of in_RegWrite
//  out_RegDest    out  5     registered copy of in_RegDest
//  sb_err         out  1     sticky; write accepted to a register with pending==0
// BEHAVIOUR
//  - Reset (async): all 32 registers = 0; all pending = 0; every registered output = 0.
//  - x0 reads 0, is never pending, and ignores writes.
//  - Write accept: a write is accepted when !stall && wb_RegWrite && wb_RegDest!=0.
//    Writeback holds its outputs under stall, so writes are never accepted while stall=1.
//    On accept: regs[dest] <= wb_data. pending[dest] decrements, saturating at 0.
//    If pending was already 0, sb_err is set.
//  - Hazard (combinational): hazard_stall = in_valid && (src1_busy || src2_busy || full).
//    srcN_busy = rsN!=0 && pending[rsN]!=0, unless cleared by the bypass rule.
//    full = in_RegWrite && in_RegDest!=0 && pending[in_RegDest]==MAX_INFLIGHT.
//  - Issue: occurs when in_valid && !hazard_stall && !stall && !flush. On issue:
//    out_* <= operands and in_* copies; out_valid <= 1.
//    If in_RegWrite && in_RegDest!=0, pending[in_RegDest] increments. Latency is 1 cycle.
//  - Bubble: when !stall && !flush && (hazard_stall || !in_valid), out_valid <= 0.
//    Data outputs hold their values.
//  - Stall (no flush): all out_* hold; pending unchanged.
//  - Simultaneous increment and decrement of the same register leaves the count unchanged.
//  - Flush: wins over stall and issue. All pending <= 0 and out_valid <= 0.
//    The register write accepted that cycle (if any) still lands. Nothing older than
//    writeback remains in flight.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - On a write-accept cycle, a read of wb_RegDest returns wb_data.
//    - srcN_busy is cleared when pending[rsN]==1 and that register is being written
//      this cycle.
//  Undefined:
//    - Reads return the array value.
//    - The hazard persists until pending reaches 0 (one extra stall cycle per RAW).
// STRUCTURE
//  - Shared package regfile_pkg: XLEN, NREGS=32, REG_ADDR_W=5, PEND_W=$clog2(MAX_INFLIGHT+1).
//  - Sub-module regfile_scoreboard: pending counters, full/busy, hazard_stall, sb_err.
//    The top level holds the array, read muxes, bypass and output registers.
// TESTING
//  1. Write x5=0xDEADBEEF via wb; next cycle issue rs1=5, rs2=0 -> out_rs1_data=0xDEADBEEF,
//     out_rs2_data=0.
//  2. Issue rd=7, then rs1=7 -> hazard_stall=1 until write of x7=0x11 is accepted.
//     BYPASS_EN: released on the write cycle with 0x11; otherwise one cycle later.
//  3. Three issues to rd=3 with no writeback, fourth attempt -> hazard_stall=1 (full);
//     one accepted write -> issue proceeds.
//  4. Hold stall=1 with wb_RegWrite=1 for 3 cycles -> register unchanged and pending
//     unchanged until stall drops; exactly one decrement then.
//  5. Pending x9=2, assert flush with wb write x9 -> pending all 0, x9 written, out_valid=0,
//     sb_err=0.
//  6. Write to x0 with 0xFFFF, or write with pending==0 -> x0 reads 0; second case sets sb_err.
//     Assert rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read stage.
// Contents: data width, register count and address width, the per-register outstanding-write
// limit, and the width of the pending counters that track those writes.
package regfile_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NREGS        = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned MAX_INFLIGHT = 3;
  localparam int unsigned PEND_W       = $clog2(MAX_INFLIGHT + 1);

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [PEND_W-1:0]     pend_t;

endpackage

// File: rtl/regfile_read_stage_if.sv
// Bundle between the pipeline (decode/writeback/execute side) and the register-file read stage.
//   master : pipeline side; drives stall/flush, the writeback write port and the decoded
//            instruction, and observes hazard_stall, the registered operands and sb_err.
//   slave  : the read stage itself.
interface regfile_read_stage_if;
  import regfile_pkg::*;

  logic      stall;
  logic      flush;
  logic      wb_RegWrite;
  reg_addr_t wb_RegDest;
  xlen_t     wb_data;
  logic      in_valid;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  logic      in_RegWrite;
  reg_addr_t in_RegDest;
  logic      hazard_stall;
  logic      out_valid;
  xlen_t     out_rs1_data;
  xlen_t     out_rs2_data;
  logic      out_RegWrite;
  reg_addr_t out_RegDest;
  logic      sb_err;

  modport master (
    output stall, flush, wb_RegWrite, wb_RegDest, wb_data,
    output in_valid, in_rs1, in_rs2, in_RegWrite, in_RegDest,
    input  hazard_stall, out_valid, out_rs1_data, out_rs2_data, out_RegWrite, out_RegDest,
    input  sb_err
  );

  modport slave (
    input  stall, flush, wb_RegWrite, wb_RegDest, wb_data,
    input  in_valid, in_rs1, in_rs2, in_RegWrite, in_RegDest,
    output hazard_stall, out_valid, out_rs1_data, out_rs2_data, out_RegWrite, out_RegDest,
    output sb_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard.
// Counts writes issued but not yet written back for each register, raises hazard_stall when a
// source is still owed a write or the destination counter is saturated, and flags (sticky)
// a writeback to a register that had nothing outstanding.
// Optional feature: `define REGFILE_BYPASS_EN releases a source whose last outstanding write
// is landing this cycle (the top-level bypasses the data).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall_i, flush_i    global stall, branch squash
//   wb_we_i, wb_dest_i  writeback write port
//   in_*                decoded instruction (valid, sources, destination)
//   hazard_stall_o      combinational hold request to decode
//   issue_o             instruction moves to the output register this cycle
//   wr_acc_o            writeback write accepted this cycle
//   sb_err_o            sticky scoreboard underflow flag
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      stall_i,
  input  logic      flush_i,
  input  logic      wb_we_i,
  input  reg_addr_t wb_dest_i,
  input  logic      in_valid_i,
  input  reg_addr_t in_rs1_i,
  input  reg_addr_t in_rs2_i,
  input  logic      in_we_i,
  input  reg_addr_t in_rd_i,
  output logic      hazard_stall_o,
  output logic      issue_o,
  output logic      wr_acc_o,
  output logic      sb_err_o
);

  localparam pend_t PendMax = pend_t'(MAX_INFLIGHT);
  localparam pend_t PendOne = pend_t'(1);

  pend_t pend_q [NREGS];
  pend_t pend_d [NREGS];
  logic  sb_err_q, sb_err_d;

  logic wr_acc, rel1, rel2, src1_busy, src2_busy, full, hazard, issue, alloc;

  // Writeback holds its outputs under stall, so a write only counts when not stalled.
  assign wr_acc = !stall_i && wb_we_i && (wb_dest_i != '0);

`ifdef REGFILE_BYPASS_EN
  // Last outstanding write landing now: the read mux forwards it, so no need to wait.
  assign rel1 = wr_acc && (wb_dest_i == in_rs1_i) && (pend_q[in_rs1_i] == PendOne);
  assign rel2 = wr_acc && (wb_dest_i == in_rs2_i) && (pend_q[in_rs2_i] == PendOne);
`else
  assign rel1 = 1'b0;
  assign rel2 = 1'b0;
`endif

  assign src1_busy = (in_rs1_i != '0) && (pend_q[in_rs1_i] != '0) && !rel1;
  assign src2_busy = (in_rs2_i != '0) && (pend_q[in_rs2_i] != '0) && !rel2;
  assign full      = in_we_i && (in_rd_i != '0) && (pend_q[in_rd_i] == PendMax);
  assign hazard    = in_valid_i && (src1_busy || src2_busy || full);
  assign issue     = in_valid_i && !hazard && !stall_i && !flush_i;
  assign alloc     = issue && in_we_i && (in_rd_i != '0);

  always_comb begin
    sb_err_d = sb_err_q;
    if (wr_acc && (pend_q[wb_dest_i] == '0)) begin
      sb_err_d = 1'b1;
    end
    for (int i = 0; i < NREGS; i++) begin
      pend_d[i] = pend_q[i];
      if (flush_i) begin
        pend_d[i] = '0;
      end else begin
        // Decrement saturates at zero; a matching inc/dec pair cancels.
        if (alloc && (in_rd_i == reg_addr_t'(i)) &&
            !(wr_acc && (wb_dest_i == reg_addr_t'(i)) && (pend_q[i] != '0))) begin
          pend_d[i] = pend_q[i] + 1'b1;
        end else if (!(alloc && (in_rd_i == reg_addr_t'(i))) &&
                     wr_acc && (wb_dest_i == reg_addr_t'(i)) && (pend_q[i] != '0)) begin
          pend_d[i] = pend_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign hazard_stall_o = hazard;
  assign issue_o        = issue;
  assign wr_acc_o       = wr_acc;
  assign sb_err_o       = sb_err_q;

endmodule

// File: rtl/regfile_read_stage.sv
// Register-file read stage: consumer end of writeback, producer of operands for execute.
// Holds the 32x32 integer register file (x0 hardwired to zero), accepts writeback writes, and
// registers two source operands plus the instruction's RegWrite/RegDest toward execute.
// A pending-write scoreboard (regfile_scoreboard) holds decode while a source is still owed
// a write.
// Optional feature: `define REGFILE_BYPASS_EN forwards the write being accepted this cycle to
// a matching source read; otherwise reads return the array and the hazard lasts one extra cycle.
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset
//   bus_io  regfile_read_stage_if.slave: stall/flush, wb_* write port, in_* instruction,
//           hazard_stall, out_* registered operands, sb_err
module regfile_read_stage
  import regfile_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  regfile_read_stage_if.slave bus_io
);

  xlen_t regs_q [NREGS];

  logic  hazard, issue, wr_acc, sb_err;
  logic  byp1, byp2;
  xlen_t rs1_val, rs2_val;

  logic      out_valid_q, out_valid_d;
  xlen_t     out_rs1_q, out_rs1_d;
  xlen_t     out_rs2_q, out_rs2_d;
  logic      out_we_q, out_we_d;
  reg_addr_t out_rd_q, out_rd_d;

  regfile_scoreboard u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (bus_io.stall),
    .flush_i        (bus_io.flush),
    .wb_we_i        (bus_io.wb_RegWrite),
    .wb_dest_i      (bus_io.wb_RegDest),
    .in_valid_i     (bus_io.in_valid),
    .in_rs1_i       (bus_io.in_rs1),
    .in_rs2_i       (bus_io.in_rs2),
    .in_we_i        (bus_io.in_RegWrite),
    .in_rd_i        (bus_io.in_RegDest),
    .hazard_stall_o (hazard),
    .issue_o        (issue),
    .wr_acc_o       (wr_acc),
    .sb_err_o       (sb_err)
  );

  // Register file; the accepted write lands even on a flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_acc) begin
      regs_q[bus_io.wb_RegDest] <= bus_io.wb_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_acc && (bus_io.wb_RegDest == bus_io.in_rs1);
  assign byp2 = wr_acc && (bus_io.wb_RegDest == bus_io.in_rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rs1_val = (bus_io.in_rs1 == '0) ? '0 :
                   byp1                  ? bus_io.wb_data : regs_q[bus_io.in_rs1];
  assign rs2_val = (bus_io.in_rs2 == '0) ? '0 :
                   byp2                  ? bus_io.wb_data : regs_q[bus_io.in_rs2];

  always_comb begin
    out_valid_d = out_valid_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_we_d    = out_we_q;
    out_rd_d    = out_rd_q;
    if (bus_io.flush) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
      out_rs1_d   = rs1_val;
      out_rs2_d   = rs2_val;
      out_we_d    = bus_io.in_RegWrite;
      out_rd_d    = bus_io.in_RegDest;
    end else if (!bus_io.stall) begin
      // Bubble: data fields keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_we_q    <= 1'b0;
      out_rd_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_we_q    <= out_we_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign bus_io.hazard_stall = hazard;
  assign bus_io.out_valid    = out_valid_q;
  assign bus_io.out_rs1_data = out_rs1_q;
  assign bus_io.out_rs2_data = out_rs2_q;
  assign bus_io.out_RegWrite = out_we_q;
  assign bus_io.out_RegDest  = out_rd_q;
  assign bus_io.sb_err       = sb_err;

endmodule
